apb4_slave_mem: RTL
===================

// Module: apb4_slave_mem
// PURPOSE
//  APB4 completer (responder) holding a small word-addressed register memory.
//  Used as the target of APB4 initiators in block and SoC benches, and as a
//  synthesizable scratch peripheral.
//  Supports runtime-programmable wait states, PSTRB byte writes, PSLVERR on bad
//  addresses, and transfer/error counters for checking.
// PARAMETERS
//  ADDR_WIDTH  32     APB address width
//  DATA_WIDTH  32     APB data width; only 32 is supported
//  DEPTH       16     number of 32-bit words; must be a power of 2
//  BASE_ADDR   32'h0  byte address of word 0; must be DEPTH*4-aligned
// PORTS
//  clk_i        in   1           APB clock (PCLK)
//  rst_i        in   1           async reset, active-high
//  paddr_i      in   ADDR_WIDTH  byte address
//  pprot_i      in   3           accepted and ignored
//  psel_i       in   1           select
//  penable_i    in   1           access phase
//  pwrite_i     in   1           1=write, 0=read
//  pwdata_i     in   DATA_WIDTH  write data
//  pstrb_i      in   DATA_WIDTH/8  byte write strobes
//  pready_o     out  1           transfer complete
//  prdata_o     out  DATA_WIDTH  read data
//  pslverr_o    out  1           transfer error
//  wait_i       in   4           wait states to insert, sampled at setup
//  xfer_cnt_o   out  16          completed transfers (ok+err), wraps
//  err_cnt_o    out  8           error transfers, saturates at 8'hFF
// BEHAVIOUR
//  Reset (async, rst_i=1)
//   - state=IDLE, wait counter=0, all memory words=0, counters=0.
//   - pready_o, pslverr_o and prdata_o are all 0.
//  FSM: IDLE, ACCESS
//   - IDLE: if psel_i & ~penable_i (setup phase):
//       - latch paddr_i, pwrite_i, pwdata_i, pstrb_i and wait_i into cnt.
//       - latch err = (paddr_i outside [BASE_ADDR, BASE_ADDR+DEPTH*4)) | (paddr_i[1:0]!=0).
//       - go to ACCESS.
//     Otherwise stay in IDLE.
//     psel_i&penable_i seen in IDLE (no setup phase) is ignored; pready_o stays 0.
//   - ACCESS: if ~psel_i, abort to IDLE; no write, no count.
//     Else if cnt!=0, cnt<=cnt-1 and stay.
//     Else (cnt==0 & penable_i) complete the transfer and return to IDLE.
//  pready_o = (state==ACCESS) & (cnt==0) & psel_i & penable_i (combinational).
//    - Latency from setup edge to completion edge is 2+wait_i cycles; wait_i=0 gives the minimal 2-cycle APB transfer.
//  pslverr_o = pready_o & err; 0 whenever pready_o=0.
//  prdata_o = mem[idx] when pready_o & ~pwrite & ~err, else 0.
//    - idx = (paddr-BASE_ADDR)>>2, log2(DEPTH) bits.
//  Write commits at the completion edge only when pwrite & ~err:
//    - byte k is updated iff pstrb[k]=1.
//    - pstrb=0 completes normally but modifies nothing.
//  Error transfer: no memory change. Completes with the same wait timing.
//  Counters, updated at each completion:
//    - xfer_cnt_o+1, wrapping 16'hFFFF->0.
//    - err_cnt_o+1 if err; holds at 8'hFF.
//  Inputs are sampled only in setup; changes to paddr/pwdata/pstrb/wait_i during ACCESS have no effect.
//  A new setup is accepted in the cycle after completion (IDLE), so back-to-back transfers are allowed.
//  rst_i mid-ACCESS: immediate IDLE, pready_o=0, no partial write.
// TESTING
//  1) wait_i=0: write 0xDEADBEEF @BASE+0x4, pstrb=4'hF, then read @BASE+0x4
//     -> each transfer pready at 2nd edge; read 0xDEADBEEF; pslverr=0; xfer_cnt=2.
//  2) wait_i=3: read @BASE+0x0 after reset
//     -> pready after exactly 3 wait cycles; prdata=0; pready low during waits.
//  3) write 0x11223344 pstrb=4'hF, then 0xAABBCCDD pstrb=4'b0101 to the same addr
//     -> read returns 0x11BB33DD.
//  4) write @BASE+DEPTH*4 and read @BASE+0x2
//     -> both complete with pslverr=1, prdata=0; memory unchanged; err_cnt=2.
//  5) assert rst_i during ACCESS of a write with wait_i=5
//     -> pready stays 0; after release, reading that addr gives 0; counters 0.
//  6) 300 error transfers, then psel dropped mid-ACCESS
//     -> err_cnt_o=8'hFF; aborted transfer not counted; xfer_cnt=300.

Source files
------------

// File: rtl/apb4_slave_mem.sv
// APB4 completer backed by a small word-addressed memory, with programmable
// wait states, byte strobes, PSLVERR on bad addresses and transfer/error counters.
module apb4_slave_mem #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic [2:0]              pprot_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic                    pready_o,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pslverr_o,
  input  logic [3:0]              wait_i,
  output logic [15:0]             xfer_cnt_o,
  output logic [7:0]              err_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int AW    = IDX_W + 2;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic {S_IDLE, S_ACCESS} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]           strb_q, strb_d;
  logic                    err_q, err_d;
  logic [15:0]             xfer_cnt_q, xfer_cnt_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

  logic setup;
  logic addr_err;
  logic done;
  logic unused_pprot;

  assign unused_pprot = ^pprot_i;
  assign setup        = psel_i & ~penable_i;
  // BASE_ADDR is window-aligned, so the window test is an upper-bits compare.
  assign addr_err     = (paddr_i[ADDR_WIDTH-1:AW] != BASE_ADDR[ADDR_WIDTH-1:AW]) |
                        (paddr_i[1:0] != 2'b00);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!psel_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0 && penable_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done      = (state_q == S_ACCESS) && (cnt_q == 4'd0) && psel_i && penable_i;
    pready_o  = done;
    pslverr_o = done & err_q;
    prdata_o  = '0;
    if (done && !write_q && !err_q) begin
      prdata_o = mem_q[idx_q];
    end
  end

  assign xfer_cnt_o = xfer_cnt_q;
  assign err_cnt_o  = err_cnt_q;

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    err_d      = err_q;
    xfer_cnt_d = xfer_cnt_q;
    err_cnt_d  = err_cnt_q;
    mem_d      = mem_q;
    if (state_q == S_IDLE && setup) begin
      cnt_d   = wait_i;
      idx_d   = paddr_i[AW-1:2];
      write_d = pwrite_i;
      wdata_d = pwdata_i;
      strb_d  = pstrb_i;
      err_d   = addr_err;
    end else if (state_q == S_ACCESS && psel_i && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (done) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
      if (err_q && err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
      if (write_q && !err_q) begin
        for (int k = 0; k < NB; k++) begin
          if (strb_q[k]) begin
            mem_d[idx_q][8*k +: 8] = wdata_q[8*k +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      err_q      <= 1'b0;
      xfer_cnt_q <= '0;
      err_cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      err_q      <= err_d;
      xfer_cnt_q <= xfer_cnt_d;
      err_cnt_q  <= err_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule
